// File: rtl/coax_tx_framer_if.sv
// Word handshake between the host command logic and the coax transmit framer.
// The producer drives data/load; the framer answers with ready (holding register empty).
interface coax_tx_framer_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] data;
  logic                  load;
  logic                  ready;

  modport master (output data, output load, input ready);
  modport slave  (input data, input load, output ready);
endinterface

// File: rtl/coax_tx_framer.sv
// Manchester-coded coax frame serialiser: start sequence, one or more sync+data(+parity)
// words chained through a one-deep holding register, then an end sequence.
module coax_tx_framer #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int DATA_WIDTH     = 10,
  parameter int QUIESCE_BITS   = 6,
  parameter int PARITY_EN      = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  coax_tx_framer_if.slave   bus,
  output logic              tx,
  output logic              active
);

  localparam int CNT_W    = $clog2(CLOCKS_PER_BIT) + 1;
  localparam int MAX_BITS = (QUIESCE_BITS > DATA_WIDTH) ? QUIESCE_BITS : DATA_WIDTH;
  localparam int IDX_W    = $clog2(MAX_BITS + 1);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] ALIGN   = 4'd1;
  localparam logic [3:0] QUIESCE = 4'd2;
  localparam logic [3:0] CV1     = 4'd3;
  localparam logic [3:0] CV2     = 4'd4;
  localparam logic [3:0] CV3     = 4'd5;
  localparam logic [3:0] SYNC    = 4'd6;
  localparam logic [3:0] DATA    = 4'd7;
  localparam logic [3:0] PARITY  = 4'd8;
  localparam logic [3:0] END0    = 4'd9;
  localparam logic [3:0] END1    = 4'd10;
  localparam logic [3:0] END2    = 4'd11;

  logic [CNT_W-1:0]      cnt;
  logic [3:0]            state;
  logic [IDX_W-1:0]      bit_idx;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_bit;
  logic                  bit_strobe;
  logic                  first_half;
  logic                  last_bit;
  logic                  take_word;
  logic                  line_level;

  assign bit_strobe = (cnt == CNT_W'(CLOCKS_PER_BIT - 1));
  assign first_half = (cnt < CNT_W'(CLOCKS_PER_BIT / 2));

  // The word-boundary decision looks only at the registered hold_valid, so a load
  // landing on that very clk is captured but too late to extend the frame.
  assign last_bit  = bit_strobe && ((PARITY_EN != 0) ? (state == PARITY)
                                   : (state == DATA && bit_idx == IDX_W'(DATA_WIDTH - 1)));
  assign take_word = (bit_strobe && state == CV3) || (last_bit && hold_valid);

  assign bus.ready = ~hold_valid;
  assign active    = (state != IDLE);

  always_comb begin
    // NOTE: default assignment first so every path drives line_level and no latch is inferred.
    line_level = 1'b0;
    case (state)
      QUIESCE, CV2, SYNC: line_level = ~first_half;
      DATA:               line_level = shift_reg[DATA_WIDTH-1] ^ first_half;
      PARITY:             line_level = par_bit ^ first_half;
      END0:               line_level = first_half;
      CV3, END1, END2:    line_level = 1'b1;
      default:            line_level = 1'b0;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt        <= '0;
      state      <= IDLE;
      bit_idx    <= '0;
      hold_valid <= 1'b0;
      tx         <= 1'b0;
    end else begin
      cnt <= bit_strobe ? '0 : cnt + 1'b1;
      tx  <= line_level;

      if (take_word)
        hold_valid <= 1'b0;
      else if (bus.load && !hold_valid)
        hold_valid <= 1'b1;

      case (state)
        IDLE:    if (hold_valid) state <= ALIGN;
        ALIGN:   if (bit_strobe) begin
                   state   <= QUIESCE;
                   bit_idx <= '0;
                 end
        QUIESCE: if (bit_strobe) begin
                   if (bit_idx == IDX_W'(QUIESCE_BITS - 1)) state <= CV1;
                   else bit_idx <= bit_idx + 1'b1;
                 end
        CV1:     if (bit_strobe) state <= CV2;
        CV2:     if (bit_strobe) state <= CV3;
        CV3:     if (bit_strobe) state <= SYNC;
        SYNC:    if (bit_strobe) begin
                   state   <= DATA;
                   bit_idx <= '0;
                 end
        DATA:    if (bit_strobe) begin
                   if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                     if (PARITY_EN != 0) state <= PARITY;
                     else                state <= hold_valid ? SYNC : END0;
                   end else begin
                     bit_idx <= bit_idx + 1'b1;
                   end
                 end
        PARITY:  if (bit_strobe) state <= hold_valid ? SYNC : END0;
        END0:    if (bit_strobe) state <= END1;
        END1:    if (bit_strobe) state <= END2;
        END2:    if (bit_strobe) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; hold_valid and state qualify every use of them.
  always_ff @(posedge clk) begin
    if (bus.load && !hold_valid)
      hold_data <= bus.data;
    if (take_word) begin
      shift_reg <= hold_data;
      par_bit   <= ^hold_data;
    end else if (state == DATA && bit_strobe) begin
      shift_reg <= shift_reg << 1;
    end
  end

endmodule

// File: tb/tb_coax_tx_framer.sv
// Bench for coax_tx_framer: two parameterisations, decoded line symbols checked against
// the frame grammar, a table of single-word frames, directed corner cases and random traffic.
module tb_coax_tx_framer;

  localparam logic [1:0] S_LOW  = 2'b00;  // {first half, second half}
  localparam logic [1:0] S_ONE  = 2'b01;
  localparam logic [1:0] S_ZERO = 2'b10;
  localparam logic [1:0] S_HIGH = 2'b11;

  logic clk = 1'b0;
  logic reset_n;
  logic tx_a, active_a, tx_b, active_b;

  coax_tx_framer_if #(.DATA_WIDTH(10)) bus_a ();
  coax_tx_framer_if #(.DATA_WIDTH(8))  bus_b ();

  coax_tx_framer #(.CLOCKS_PER_BIT(8), .DATA_WIDTH(10), .QUIESCE_BITS(6), .PARITY_EN(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .tx(tx_a), .active(active_a));
  coax_tx_framer #(.CLOCKS_PER_BIT(4), .DATA_WIDTH(8), .QUIESCE_BITS(4), .PARITY_EN(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .tx(tx_b), .active(active_b));

  always #5 clk = ~clk;

  int n = 0;  // rising edges since reset released; the bit phase is derived from it
  always @(posedge clk) n <= reset_n ? n + 1 : 0;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  int          runs_a[$], gaps_a[$], runs_b[$], gaps_b[$];
  bit          saw_end0;
  logic        last_par;

  typedef struct {
    bit          sel;
    logic [15:0] word;
    logic        exp_par;
    int          exp_bits;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic txv(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? bus_b.ready : bus_a.ready;
  endfunction

  // Active-high run lengths and the low gap preceding each run, per DUT.
  initial begin
    int ra, la, ga, rb, lb, gb;
    ra = 0; la = 0; ga = 0; rb = 0; lb = 0; gb = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        ra = 0; la = 0; rb = 0; lb = 0;
      end else begin
        if (active_a) begin
          if (ra == 0) begin ga = la; la = 0; end
          ra++;
        end else begin
          if (ra > 0) begin runs_a.push_back(ra); gaps_a.push_back(ga); ra = 0; end
          la++;
        end
        if (active_b) begin
          if (rb == 0) begin gb = lb; lb = 0; end
          rb++;
        end else begin
          if (rb > 0) begin runs_b.push_back(rb); gaps_b.push_back(gb); rb = 0; end
          lb++;
        end
      end
    end
  end

  // One bit-time of line: tx seen after edge n carries bit phase (n-1) mod cpb.
  task automatic get_sym(input int cpb, input bit sel, output logic [1:0] s);
    int   p;
    logic h1, h2;
    bit   bad;
    do begin
      @(negedge clk);
      p = (n + cpb - 1) % cpb;
    end while (p != 0);
    h1 = txv(sel); h2 = 1'b0; bad = 1'b0;
    for (int i = 1; i < cpb; i++) begin
      @(negedge clk);
      if (i == cpb / 2) h2 = txv(sel);
      else if (txv(sel) !== ((i < cpb / 2) ? h1 : h2)) bad = 1'b1;
    end
    check("half-bit stable", {31'd0, bad}, 32'd0);
    s = {h1, h2};
  endtask

  task automatic do_load(input bit sel, input logic [15:0] word, input int max_wait);
    int w;
    w = 0;
    @(negedge clk);
    while (!rdy(sel) && w < max_wait) begin @(negedge clk); w++; end
    if (!rdy(sel)) begin fail("ready wait timeout"); return; end
    if (sel) begin bus_b.data = word[7:0]; bus_b.load = 1'b1; end
    else     begin bus_a.data = word[9:0]; bus_a.load = 1'b1; end
    exp_q.push_back(word);
    @(negedge clk);
    bus_a.load = 1'b0; bus_b.load = 1'b0;
    check("ready drops after load", {31'd0, rdy(sel)}, 32'd0);
  endtask

  // Decode one frame against the frame grammar; words are checked against exp_q.
  task automatic rx_frame(input bit sel, input int idle_max, output int nw, output int run,
                          output int gap, output bit ok);
    int          cpb, dw, qb, pe, idle;
    logic [1:0]  s;
    logic [15:0] word, e;
    cpb = sel ? 4 : 8; dw = sel ? 8 : 10; qb = sel ? 4 : 6; pe = sel ? 0 : 1;
    nw = 0; run = -1; gap = -1; ok = 1'b1; idle = 0;
    get_sym(cpb, sel, s);
    while (s == S_LOW && idle < idle_max) begin idle++; get_sym(cpb, sel, s); end
    if (s == S_LOW) begin fail("frame start timeout"); ok = 1'b0; return; end
    check("quiesce", s, S_ONE);
    for (int i = 1; i < qb; i++) begin get_sym(cpb, sel, s); check("quiesce", s, S_ONE); end
    get_sym(cpb, sel, s); check("cv1 low", s, S_LOW);
    get_sym(cpb, sel, s); check("cv2 one", s, S_ONE);
    get_sym(cpb, sel, s); check("cv3 high", s, S_HIGH);
    get_sym(cpb, sel, s); check("sync", s, S_ONE);
    do begin
      word = '0;
      for (int i = 0; i < dw; i++) begin
        get_sym(cpb, sel, s);
        if (s != S_ONE && s != S_ZERO) check("data symbol", s, S_ONE);
        word = {word[14:0], s == S_ONE};
      end
      e = '0;
      if (exp_q.size() == 0) fail("unexpected word");
      else begin e = exp_q.pop_front(); check("word", word, e); end
      if (pe != 0) begin
        get_sym(cpb, sel, s);
        if (s != S_ONE && s != S_ZERO) check("parity symbol", s, S_ONE);
        last_par = (s == S_ONE);
        check("even parity", {31'd0, last_par}, {31'd0, ^e});
      end
      nw++;
      get_sym(cpb, sel, s);
    end while (s == S_ONE && nw < 64);
    check("end0 zero", s, S_ZERO);
    saw_end0 = 1'b1;
    get_sym(cpb, sel, s); check("end1 high", s, S_HIGH);
    get_sym(cpb, sel, s); check("end2 high", s, S_HIGH);
    get_sym(cpb, sel, s); check("line idle", s, S_LOW);
    if (sel) begin
      if (runs_b.size() > 0) begin run = runs_b.pop_front(); gap = gaps_b.pop_front(); end
    end else begin
      if (runs_a.size() > 0) begin run = runs_a.pop_front(); gap = gaps_a.pop_front(); end
    end
  endtask

  function automatic int frame_bits(input bit sel, input int nw);
    return sel ? (4 + 3 + nw * 9 + 3) : (6 + 3 + nw * 12 + 3);
  endfunction

  initial begin
    int nw, nw2, run, run2, gap, gap2, cpb, got, guard, hi_cnt, act_cnt;
    bit ok;

    tbl[0] = '{1'b0, 16'h0305, 1'b0, 24};
    tbl[1] = '{1'b0, 16'h0001, 1'b1, 24};
    tbl[2] = '{1'b0, 16'h03FF, 1'b0, 24};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 24};
    tbl[4] = '{1'b0, 16'h0200, 1'b1, 24};
    tbl[5] = '{1'b1, 16'h00A5, 1'b0, 19};
    tbl[6] = '{1'b1, 16'h00FF, 1'b0, 19};
    tbl[7] = '{1'b1, 16'h0001, 1'b0, 19};

    reset_n = 1'b0;
    bus_a.data = '0; bus_a.load = 1'b0;
    bus_b.data = '0; bus_b.load = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", {31'd0, tx_a}, 32'd0);
    check("reset active", {31'd0, active_a}, 32'd0);
    check("reset ready", {31'd0, bus_a.ready}, 32'd1);
    check("reset ready b", {31'd0, bus_b.ready}, 32'd1);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      cpb = tbl[i].sel ? 4 : 8;
      fork
        do_load(tbl[i].sel, tbl[i].word, 200);
        rx_frame(tbl[i].sel, 40, nw, run, gap, ok);
      join
      check("table words per frame", nw, 1);
      check_rng("table frame length", run, tbl[i].exp_bits * cpb + 1, tbl[i].exp_bits * cpb + cpb);
      if (!tbl[i].sel) check("table parity", {31'd0, last_par}, {31'd0, tbl[i].exp_par});
      repeat ($urandom_range(0, 9)) @(negedge clk);
    end

    // Back-to-back: second word loaded the first cycle ready returns.
    fork
      begin do_load(1'b0, 16'h0001, 200); do_load(1'b0, 16'h03FF, 400); end
      rx_frame(1'b0, 40, nw, run, gap, ok);
    join
    check("back-to-back words", nw, 2);
    check_rng("back-to-back length", run, 36 * 8 + 1, 36 * 8 + 8);

    // Overflow: load while ready is low must be ignored.
    fork
      begin
        do_load(1'b0, 16'h00F0, 200);
        @(negedge clk);
        bus_a.data = 10'h155; bus_a.load = 1'b1;
        @(negedge clk);
        bus_a.load = 1'b0;
        check("ready held low on overflow", {31'd0, bus_a.ready}, 32'd0);
      end
      rx_frame(1'b0, 40, nw, run, gap, ok);
    join
    check("overflow words", nw, 1);

    // Load during END1: frame ends, one IDLE clock, then a fresh frame.
    saw_end0 = 1'b0;
    fork
      begin
        int w;
        do_load(1'b0, 16'h0305, 200);
        w = 0;
        while (!saw_end0 && w < 2000) begin @(negedge clk); w++; end
        if (!saw_end0) fail("end0 wait timeout");
        else do_load(1'b0, 16'h02AA, 4);
      end
      begin
        rx_frame(1'b0, 40, nw, run, gap, ok);
        rx_frame(1'b0, 40, nw2, run2, gap2, ok);
      end
    join
    check("end-load first frame words", nw, 1);
    check("end-load second frame words", nw2, 1);
    check("end-load idle gap", gap2, 1);
    check("end-load parity", {31'd0, last_par}, 32'd1);
    check_rng("end-load second length", run2, 24 * 8 + 1, 24 * 8 + 8);

    // Reset mid-DATA: frame abandoned, line silent afterwards.
    do_load(1'b0, 16'h03C3, 200);
    repeat (112) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid-frame reset tx", {31'd0, tx_a}, 32'd0);
    check("mid-frame reset active", {31'd0, active_a}, 32'd0);
    check("mid-frame reset ready", {31'd0, bus_a.ready}, 32'd1);
    reset_n = 1'b1;
    hi_cnt = 0; act_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_a) hi_cnt++;
      if (active_a) act_cnt++;
    end
    check("silent after reset tx", hi_cnt, 0);
    check("silent after reset active", act_cnt, 0);
    exp_q.delete(); runs_a.delete(); gaps_a.delete();

    // Random traffic: mixture of chained words and isolated frames.
    got = 0; guard = 0; ok = 1'b1;
    fork
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(150, 400)) @(negedge clk);
        else repeat ($urandom_range(0, 20)) @(negedge clk);
        do_load(1'b0, 16'($urandom_range(0, 1023)), 2000);
      end
      while (got < 12 && ok && guard < 12) begin
        rx_frame(1'b0, 80, nw, run, gap, ok);
        if (ok) check_rng("random frame length", run, frame_bits(1'b0, nw) * 8 + 1,
                          frame_bits(1'b0, nw) * 8 + 8);
        got += nw;
        guard++;
      end
    join
    check("random words received", got, 12);
    check("random queue drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
